// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Operation and state encodings plus small decode helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } muldiv_state_t;

  // Signed ops work on magnitudes and fix the signs up at the end.
  function automatic logic op_is_signed(input muldiv_op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift in one dividend bit, trial-subtract
// the divisor, keep the difference if it did not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_i, bit_i};
  assign trial   = shifted - {1'b0, divisor_i};

  // With rem < divisor the shifted value is below 2*divisor, so a negative
  // trial always shows up as the top bit of the WIDTH+1 difference.
  assign q_o   = ~trial[WIDTH];
  assign rem_o = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair.
// One product/quotient bit per cycle; start/busy/done handshake, cancel for
// pipeline flush, and mthi/mtlo write ports.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies stop as soon as the
// remaining multiplier bits are zero, and divide-by-zero skips the iteration
// phase entirely.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  muldiv_state_t    state_q;
  muldiv_op_t       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sa_q, sb_q;
  logic [WIDTH-1:0] a_orig_q;
  // Multiply: running product. Divide: {partial remainder, dividend/quotient}.
  logic [PW-1:0]    prod_q;
  // Multiply: left-shifting multiplicand. Divide: divisor in the low half.
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;

  // Input-side decode and operand magnitudes for the launch cycle.
  muldiv_op_t       op_in;
  logic             in_signed, in_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign op_in     = muldiv_op_t'(op);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign a_neg     = in_signed & a[WIDTH-1];
  assign b_neg     = in_signed & b[WIDTH-1];
  assign a_abs     = a_neg ? -a : a;
  assign b_abs     = b_neg ? -b : b;

  logic is_div_q;
  assign is_div_q = op_is_div(op_q);

  // Per-cycle multiply step: conditionally accumulate the shifted multiplicand.
  logic [PW-1:0] mul_sum;
  assign mul_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Per-cycle divide step.
  logic [WIDTH-1:0] div_rem;
  logic             div_qbit;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (prod_q[PW-1:WIDTH]),
    .bit_i     (prod_q[WIDTH-1]),
    .divisor_i (mcand_q[WIDTH-1:0]),
    .rem_o     (div_rem),
    .q_o       (div_qbit)
  );

  // Early-exit conditions; tied off in the fixed-latency build.
  logic early_div0, early_mul;
`ifdef MULDIV_EARLY_OUT_EN
  assign early_div0 = in_div && (b == '0);
  assign early_mul  = !is_div_q && ((mplier_q >> 1) == '0);
`else
  assign early_div0 = 1'b0;
  assign early_mul  = 1'b0;
`endif

  // Sign fix-up and special cases applied when the result is written back.
  logic [PW-1:0]    mul_res;
  logic [WIDTH-1:0] quo, rem;
  logic             div_by_zero;

  assign mul_res     = (sa_q ^ sb_q) ? -prod_q : prod_q;
  assign quo         = prod_q[WIDTH-1:0];
  assign rem         = prod_q[PW-1:WIDTH];
  assign div_by_zero = (mcand_q[WIDTH-1:0] == '0);

  logic [WIDTH-1:0] fix_hi, fix_lo;

  // Select the final HI/LO values for the FIX cycle.
  always_comb begin
    fix_hi = mul_res[PW-1:WIDTH];
    fix_lo = mul_res[WIDTH-1:0];
    if (is_div_q) begin
      if (div_by_zero) begin
        fix_hi = a_orig_q;
        fix_lo = '1;
      end else begin
        fix_hi = sa_q ? -rem : rem;
        fix_lo = (sa_q ^ sb_q) ? -quo : quo;
      end
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_orig_q <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // mthi/mtlo only land while idle; a completion later overwrites them.
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start && !cancel) begin
            op_q     <= op_in;
            sa_q     <= a_neg;
            sb_q     <= b_neg;
            a_orig_q <= a;
            cnt_q    <= CNT_W'(WIDTH);
            busy_q   <= 1'b1;
            mplier_q <= b_abs;
            if (in_div) begin
              prod_q  <= {{WIDTH{1'b0}}, a_abs};
              mcand_q <= {{WIDTH{1'b0}}, b_abs};
            end else begin
              prod_q  <= '0;
              mcand_q <= {{WIDTH{1'b0}}, a_abs};
            end
            state_q <= early_div0 ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          if (cancel) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (is_div_q) begin
              prod_q <= {div_rem, prod_q[WIDTH-2:0], div_qbit};
            end else begin
              prod_q   <= mul_sum;
              mcand_q  <= mcand_q << 1;
              mplier_q <= mplier_q >> 1;
            end
            if (cnt_q == CNT_W'(1) || early_mul) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!cancel) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random vectors
// against a native-arithmetic model, and hand-written cancel/mthi/mtlo/reset
// sequences. Results are scoreboarded and checked when done pulses.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, cancel, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct packed {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sbq[$];
  int          n_pass   = 0;
  int          n_checks = 0;
  logic [31:0] last_hi  = 32'h0;
  logic [31:0] last_lo  = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference result {hi, lo} from native arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (o == 2'b00) begin
      q = sx * sy;
      p = q;
      return p;
    end
    if (o == 2'b01) return ux * uy;
    if (y == 32'h0) return {x, 32'hFFFFFFFF};
    if (o == 2'b10) begin
      q = sx / sy;
      r = sx % sy;
    end else begin
      q = longint'(ux / uy);
      r = longint'(ux % uy);
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Completion latency in cycles after the start edge for the early-out build.
  function automatic int early_lat(input logic [1:0] o, input logic [31:0] y);
    logic [31:0] m;
    int          k;
    if (o[1]) return (y == 32'h0) ? 1 : W + 1;
    m = (!o[0] && y[31]) ? -y : y;
    k = 1;
    for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
    return k + 1;
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
    int l;
`ifdef MULDIV_EARLY_OUT_EN
    l = early_lat(o, y);
`else
    l = W + 1;
    if (o == 2'b11 && y == 32'hFFFF_FFFF) l = W + 1;
`endif
    return l;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      check("pending_at_done", 32'(sbq.size() > 0), 32'd1);
      check("busy_low_at_done", 32'(busy), 32'd0);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check($sformatf("hi[%0d]", e.id), hi, e.hi);
        check($sformatf("lo[%0d]", e.id), lo, e.lo);
        $display("op %0d done: hi=%h lo=%h", e.id, hi, lo);
      end
    end
  end

  // Drive one start; returns at the negedge after the start edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit push, input logic [31:0] ehi, input logic [31:0] elo, input int id);
    exp_t e;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    if (push) begin
      e.id = id; e.hi = ehi; e.lo = elo;
      sbq.push_back(e);
      last_hi = ehi;
      last_lo = elo;
    end
    @(negedge clk);
    start = 1'b0;
    check($sformatf("busy_after_start[%0d]", id), 32'(busy), 32'd1);
  endtask

  // Bounded wait for done; checks cycles from the start edge.
  task automatic wait_done(input int lat, input int already, input int id);
    int cyc = already;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("latency[%0d]", id), 32'(cyc), 32'(lat));
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo, input int id);
    start_op(o, x, y, 1'b1, ehi, elo, id);
    wait_done(exp_lat(o, y), 0, id);
  endtask

  initial begin
    vec_t        vt[$];
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] m;

    reset = 1'b1; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;

    vt.push_back({2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE});
    vt.push_back({2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vt.push_back({2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vt.push_back({2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vt.push_back({2'b11, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF});
    vt.push_back({2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF});
    vt.push_back({2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vt.push_back({2'b00, 32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF, 32'h00000000});
    vt.push_back({2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000});
    vt.push_back({2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF});
    vt.push_back({2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vt.push_back({2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002});
    vt.push_back({2'b00, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000});

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < vt.size(); i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, i);

    // Random vectors against the native-arithmetic model.
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31);
      m  = model(ro, ra, rb);
      run_op(ro, ra, rb, m[63:32], m[31:0], 100 + i);
    end

    // Cancel mid-calculation: no done, HI/LO untouched, busy drops.
    start_op(2'b01, 32'd3, 32'd5, 1'b0, 32'h0, 32'h0, 200);
    repeat (3) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_hi", hi, last_hi);
    check("cancel_lo", lo, last_lo);
    repeat (40) @(negedge clk);

    // Cancel beats start in the same cycle.
    @(negedge clk);
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_beats_start_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);

    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 201);

    // mtlo while busy is dropped; the op still completes.
    start_op(2'b01, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15, 202);
    lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_busy_ignored", lo, 32'd14);
    wait_done(exp_lat(2'b01, 32'd5), 1, 202);

    // mtlo / mthi while idle.
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_idle", lo, 32'h1234);
    check("mtlo_idle_hi_kept", hi, 32'h0);
    hi_we = 1'b1; wdata = 32'hABCD0001;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_idle", hi, 32'hABCD0001);
    check("mthi_idle_lo_kept", lo, 32'h1234);

    // Reset in the middle of an operation.
    start_op(2'b11, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 203);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_hi", hi, 32'h0);
    check("midreset_lo", lo, 32'h0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    repeat (40) @(negedge clk);

    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
